// File: rtl/vote_tally_engine.sv
// vote_tally_engine
// Multi-candidate vote tally engine. It takes one-hot ballots on the rising
// edge of confirm and keeps saturating per-candidate and total counters.
// A sequential scan, one candidate per cycle, finds the winner and flags
// ties. Any candidate counter can be read back by index.
// Optional feature: define VOTE_LOCKOUT_EN to block votes for LOCKOUT_CYC
// cycles after each accepted vote.
module vote_tally_engine #(
    parameter int NUM_CAND    = 8,
    parameter int CNT_W       = 16,
    parameter int LOCKOUT_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CAND-1:0]         vote_sel,
    input  logic                        confirm,
    input  logic [1:0]                  cmd,
    input  logic [$clog2(NUM_CAND)-1:0] rd_idx,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            total,
    output logic [NUM_CAND-1:0]         winner,
    output logic                        tie,
    output logic                        result_valid,
    output logic                        busy,
    output logic                        vote_ack,
    output logic                        vote_err
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    localparam logic [1:0] CMD_VOTE  = 2'b00;
    localparam logic [1:0] CMD_COUNT = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        ST_VOTE,
        ST_SCAN,
        ST_RESULT,
        ST_CLEAR
    } state_t;

    // Out-of-range parameters stop elaboration instead of building bad hardware.
    if (NUM_CAND < 2 || NUM_CAND > 16 || CNT_W < 1 || LOCKOUT_CYC < 1) begin : g_param_check
        $error("vote_tally_engine: parameter out of range");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_CAND];
    logic               confirm_d;
    logic               rise;

    logic [IDX_W-1:0]   scan_idx;
    logic [CNT_W-1:0]   max_cnt;
    logic [IDX_W-1:0]   max_idx;
    logic               scan_tie;

    logic [CNT_W-1:0]   nxt_max;
    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_tie;

    logic               sel_onehot;
    logic               sel_sat;
    logic [IDX_W-1:0]   sel_idx;
    logic               lock_busy;
    logic               vote_ok;

    assign rise = confirm & ~confirm_d;
    assign busy = (state == ST_SCAN) || (state == ST_CLEAR);

    // Decode the ballot: one-hot check, its index, and whether its counter is full.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_sat = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (vote_sel[k]) begin
                sel_idx = IDX_W'(k);
                if (cnt[k] == '1) sel_sat = 1'b1;
            end
        end
        sel_onehot = (vote_sel != '0) &&
                     ((vote_sel & (vote_sel - NUM_CAND'(1))) == '0);
    end

    assign vote_ok = (state == ST_VOTE) && (cmd == CMD_VOTE) && rise &&
                     sel_onehot && !sel_sat && (total != '1) && !lock_busy;

    // Running-max update for the candidate currently under the scan pointer.
    always_comb begin
        nxt_max = max_cnt;
        nxt_idx = max_idx;
        nxt_tie = scan_tie;
        if (cnt[scan_idx] > max_cnt) begin
            nxt_max = cnt[scan_idx];
            nxt_idx = scan_idx;
            nxt_tie = 1'b0;
        end else if ((cnt[scan_idx] == max_cnt) && (max_cnt != '0)) begin
            nxt_tie = 1'b1;
        end
    end

    // Control FSM: scan sequencing and registered winner/tie/result_valid.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= ST_VOTE;
            scan_idx     <= '0;
            max_cnt      <= '0;
            max_idx      <= '0;
            scan_tie     <= 1'b0;
            winner       <= '0;
            tie          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_VOTE: begin
                    if (cmd == CMD_COUNT) begin
                        state    <= ST_SCAN;
                        scan_idx <= '0;
                        max_cnt  <= '0;
                        max_idx  <= '0;
                        scan_tie <= 1'b0;
                    end else if (cmd == CMD_CLEAR) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_SCAN: begin
                    if (cmd == CMD_CLEAR) begin
                        state <= ST_CLEAR;
                    end else begin
                        max_cnt  <= nxt_max;
                        max_idx  <= nxt_idx;
                        scan_tie <= nxt_tie;
                        if (scan_idx == LAST_IDX) begin
                            state        <= ST_RESULT;
                            result_valid <= 1'b1;
                            tie          <= nxt_tie;
                            winner       <= ((nxt_max != '0) && !nxt_tie) ?
                                            (NUM_CAND'(1) << nxt_idx) : '0;
                        end else begin
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    if (cmd == CMD_VOTE || cmd == CMD_CLEAR) begin
                        state        <= (cmd == CMD_VOTE) ? ST_VOTE : ST_CLEAR;
                        winner       <= '0;
                        tie          <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    winner       <= '0;
                    tie          <= 1'b0;
                    result_valid <= 1'b0;
                    if (cmd != CMD_CLEAR) state <= ST_VOTE;
                end
                default: state <= ST_VOTE;
            endcase
        end
    end

    // Ballot acceptance: edge detect, saturating counters, ack/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // confirm_d resets high so a confirm held through reset is not an edge.
            confirm_d <= 1'b1;
            // NOTE: the counter array is reset because reset must read back all-zero counts.
            for (int k = 0; k < NUM_CAND; k++) cnt[k] <= '0;
            total    <= '0;
            vote_ack <= 1'b0;
            vote_err <= 1'b0;
        end else begin
            confirm_d <= confirm;
            vote_ack  <= vote_ok;
            vote_err  <= rise & ~vote_ok;
            if (state == ST_CLEAR) begin
                for (int k = 0; k < NUM_CAND; k++) cnt[k] <= '0;
                total <= '0;
            end else if (vote_ok) begin
                cnt[sel_idx] <= cnt[sel_idx] + CNT_W'(1);
                total        <= total + CNT_W'(1);
            end
        end
    end

    // Readout register, sampled from the pre-edge counter values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (32'(rd_idx) < NUM_CAND) begin
            rd_count <= cnt[rd_idx];
        end else begin
            rd_count <= '0;
        end
    end

`ifdef VOTE_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCKOUT_CYC + 1);

    logic [LK_W-1:0] lock_cnt;

    // Post-vote lockout down-counter; nonzero blocks new ballots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            lock_cnt <= '0;
        end else if (vote_ok) begin
            lock_cnt <= LK_W'(LOCKOUT_CYC);
        end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LK_W'(1);
        end
    end

    assign lock_busy = (lock_cnt != '0);
`else
    assign lock_busy = 1'b0;
`endif

endmodule
